// File: rtl/nonogram_pkg.sv
// Shared types and constants for the nonogram job sequencer and its result streamer.
package nonogram_pkg;

    localparam int DIM_W      = 12;
    localparam int CELLS_W    = 24;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SOLVE = 2'd2,
        DUMP  = 2'd3
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNSAT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_DIMS    = 2'd3;

endpackage

// File: rtl/nonogram_sequencer_result_streamer.sv
// Walks the result region one cell at a time: read a word, then present its bit 0
// on a valid/ready stream until accepted.
module result_streamer
    import nonogram_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESULT_BASE = ADDR_W'(16'h8000)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CELLS_W-1:0] cells,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_bit,
    output logic               out_valid,
    output logic               out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               done
);

    logic               active_q, active_d;
    logic               pres_q, pres_d;
    logic               fresh_q, fresh_d;
    logic               hold_q, hold_d;
    logic [CELLS_W-1:0] idx_q, idx_d;
    logic [CELLS_W-1:0] last_idx_q, last_idx_d;

    // Stream handshake: a cell transfers on a cycle where out_valid && out_ready;
    // once out_valid rises, out_data and out_last stay fixed until that transfer.
    always_comb begin
        active_d   = active_q;
        pres_d     = pres_q;
        fresh_d    = 1'b0;
        hold_d     = hold_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        done       = 1'b0;
        if (start) begin
            active_d   = 1'b1;
            pres_d     = 1'b0;
            idx_d      = '0;
            last_idx_d = cells - 1'b1;
        end else if (active_q) begin
            if (!pres_q) begin
                pres_d  = 1'b1;
                fresh_d = 1'b1;
            end else begin
                // The BRAM word is only guaranteed in the first presenting cycle.
                if (fresh_q) hold_d = rd_bit;
                if (out_ready) begin
                    pres_d = 1'b0;
                    if (idx_q == last_idx_q) begin
                        active_d = 1'b0;
                        done     = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        end
    end

    assign rd_en     = active_q && !pres_q;
    assign rd_addr   = rd_en ? RESULT_BASE + ADDR_W'(idx_q) : '0;
    assign out_valid = active_q && pres_q;
    assign out_data  = out_valid && (fresh_q ? rd_bit : hold_q);
    assign out_last  = out_valid && (idx_q == last_idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            pres_q     <= 1'b0;
            fresh_q    <= 1'b0;
            hold_q     <= 1'b0;
            idx_q      <= '0;
            last_idx_q <= '0;
        end else begin
            active_q   <= active_d;
            pres_q     <= pres_d;
            fresh_q    <= fresh_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
        end
    end

endmodule

// File: rtl/nonogram_sequencer.sv
// Single BRAM master that sequences one nonogram job: parser load, solver run,
// then streaming of the solved cells.
module nonogram_sequencer
    import nonogram_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                DATA_W         = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESULT_BASE    = ADDR_W'(16'h8000),
    parameter int                TIMEOUT_CYCLES = 2**24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_write_ready,
    input  logic [DATA_W-1:0] p_assignment,
    input  logic [ADDR_W-1:0] p_bram_index,
    input  logic              p_board_done,
    input  logic [DIM_W-1:0]  p_n,
    input  logic [DIM_W-1:0]  p_m,
    output logic              s_start,
    output logic [DIM_W-1:0]  s_n,
    output logic [DIM_W-1:0]  s_m,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_rvalid,
    output logic [DATA_W-1:0] s_rdata,
    input  logic              s_done,
    input  logic              s_unsat,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              out_valid,
    output logic              out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [1:0]        err_code,
    output logic              overrun
);

    localparam logic [CELLS_W-1:0] TIMEOUT_LAST = CELLS_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [1:0]         err_q, err_d;
    logic               overrun_q, overrun_d;
    logic               s_start_q, s_start_d;
    logic               s_rvalid_q, s_rvalid_d;
    logic [DIM_W-1:0]   s_n_q, s_n_d, s_m_q, s_m_d;
    logic [CELLS_W-1:0] cells_q, cells_d, cyc_q, cyc_d;
    logic               stream_start, stream_done, rd_en;
    logic [ADDR_W-1:0]  rd_addr;

    result_streamer #(
        .ADDR_W      (ADDR_W),
        .RESULT_BASE (RESULT_BASE)
    ) u_streamer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (stream_start),
        .cells     (cells_q),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_bit    (bram_rdata[0]),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (stream_done)
    );

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        overrun_d    = overrun_q | (p_write_ready && (state_q == SOLVE || state_q == DUMP));
        s_start_d    = 1'b0;
        s_rvalid_d   = (state_q == SOLVE) && s_req && !s_we;
        s_n_d        = s_n_q;
        s_m_d        = s_m_q;
        cells_d      = cells_q;
        stream_start = 1'b0;
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_wdata   = '0;
        case (state_q)
            IDLE, LOAD: begin
                if (p_write_ready) begin
                    bram_en    = 1'b1;
                    bram_we    = 1'b1;
                    bram_addr  = p_bram_index;
                    bram_wdata = p_assignment;
                    if (state_q == IDLE) begin
                        state_d = LOAD;
                        err_d   = ERR_NONE;
                    end
                end
                if (p_board_done) begin
                    s_n_d = p_n;
                    s_m_d = p_m;
                    if (p_n == '0 || p_m == '0) begin
                        err_d   = ERR_DIMS;
                        state_d = IDLE;
                    end else begin
                        cells_d   = CELLS_W'(p_n) * CELLS_W'(p_m);
                        state_d   = SOLVE;
                        s_start_d = 1'b1;
                    end
                end
            end
            SOLVE: begin
                bram_en    = s_req;
                bram_we    = s_req && s_we;
                bram_addr  = s_req ? s_addr : '0;
                bram_wdata = (s_req && s_we) ? s_wdata : '0;
                if (s_done) begin
                    state_d      = DUMP;
                    stream_start = 1'b1;
                end else if (s_unsat) begin
                    err_d   = ERR_UNSAT;
                    state_d = IDLE;
                end else if (cyc_q == TIMEOUT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            default: begin
                bram_en   = rd_en;
                bram_addr = rd_addr;
                if (stream_done) begin
                    err_d   = ERR_NONE;
                    state_d = IDLE;
                end
            end
        endcase
        // The watchdog counts only consecutive SOLVE cycles of the current job.
        cyc_d = (state_q == SOLVE && state_d == SOLVE) ? cyc_q + 1'b1 : '0;
    end

    assign s_start  = s_start_q;
    assign s_n      = s_n_q;
    assign s_m      = s_m_q;
    assign s_rvalid = s_rvalid_q;
    assign s_rdata  = s_rvalid_q ? bram_rdata : '0;
    assign busy     = (state_q != IDLE);
    assign err_code = err_q;
    assign overrun  = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            overrun_q  <= 1'b0;
            s_start_q  <= 1'b0;
            s_rvalid_q <= 1'b0;
            s_n_q      <= '0;
            s_m_q      <= '0;
            cells_q    <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
            s_start_q  <= s_start_d;
            s_rvalid_q <= s_rvalid_d;
            s_n_q      <= s_n_d;
            s_m_q      <= s_m_d;
            cells_q    <= cells_d;
            cyc_q      <= cyc_d;
        end
    end

endmodule

// File: doc/nonogram_sequencer.md
# nonogram_sequencer

Top-level controller that owns the single port of the constraint/result BRAM and sequences one nonogram job end to end. It accepts the parser's write stream (`write_ready`, `assignment`, `bram_index`, `board_done`, `n`, `m`) into BRAM, then launches the solver and grants it exclusive BRAM access. It then streams the solved cell values out to the UART transmit path. It sits between parser, solver core and tx serializer, and is the only BRAM master.

## Interface

Parameters:
- `ADDR_W`, 16: BRAM address width.
- `DATA_W`, 13: BRAM word width; matches the parser `assignment` width.
- `RESULT_BASE`, 16'h8000: BRAM address of cell 0 of the result region.
- `TIMEOUT_CYCLES`, 2**24: maximum number of SOLVE cycles before the job aborts.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low; all state clears immediately on assertion.
- `p_write_ready` in 1: parser write strobe.
- `p_assignment` in DATA_W: parser write data.
- `p_bram_index` in ADDR_W: parser write address.
- `p_board_done` in 1: parser end-of-board strobe.
- `p_n`, `p_m` in 12: board dimensions; valid when `p_board_done` is high.
- `s_start` out 1: one-cycle solver launch pulse.
- `s_n`, `s_m` out 12: latched board dimensions.
- `s_req` in 1: solver BRAM access request.
- `s_we` in 1: solver BRAM write enable.
- `s_addr` in ADDR_W: solver BRAM address.
- `s_wdata` in DATA_W: solver BRAM write data.
- `s_rvalid` out 1: solver read data valid.
- `s_rdata` out DATA_W: solver read data.
- `s_done` in 1: solver finished, solution written.
- `s_unsat` in 1: solver finished, no solution exists.
- `bram_en` out 1: BRAM port enable.
- `bram_we` out 1: BRAM write enable.
- `bram_addr` out ADDR_W: BRAM address.
- `bram_wdata` out DATA_W: BRAM write data.
- `bram_rdata` in DATA_W: BRAM read data; 1-cycle read latency.
- `out_valid` out 1: result stream valid.
- `out_data` out 1: value of the current cell.
- `out_last` out 1: marks the final cell of the result stream.
- `out_ready` in 1: result stream ready.
- `busy` out 1: high in LOAD, SOLVE and DUMP.
- `err_code` out 2: job status; 0 none, 1 unsat, 2 timeout, 3 bad dimensions.
- `overrun` out 1: sticky flag for parser writes dropped outside IDLE/LOAD.

## Operation

States:
- IDLE: waits for the parser. The first `p_write_ready` is written and moves the block to LOAD. `p_board_done` moves it directly to the dimension check.
- LOAD: each `p_write_ready` becomes a BRAM write (`bram_en`=`bram_we`=1, addr/data passed straight through). On `p_board_done`, latch `p_n`/`p_m`.
  - If either dimension is 0, set `err_code`=3 and go to IDLE.
  - Otherwise register `cells = n*m` (24-bit) and go to SOLVE.
  - A `p_write_ready` and `p_board_done` in the same cycle: the write is performed, then the transition happens.
- SOLVE: `s_start` pulses in the first SOLVE cycle. While in SOLVE, `s_req` drives the BRAM port directly. Reads return on `s_rvalid`/`s_rdata` one cycle after `s_req && !s_we`. A 24-bit cycle counter runs.
  - `s_done`: go to DUMP.
  - `s_unsat`: `err_code`=1, go to IDLE.
  - Counter reaches `TIMEOUT_CYCLES-1`: `err_code`=2, go to IDLE.
  - Priority when several fire together: `s_done` > `s_unsat` > timeout.
- DUMP: for i = 0..cells-1:
  - Read `RESULT_BASE+i`.
  - Present `bram_rdata[0]` on `out_data` with `out_valid`=1.
  - Hold the value until `out_valid && out_ready`.
  - `out_last`=1 for i = cells-1.
  - After the last handshake, go to IDLE with `err_code`=0.
- Outside their owning state, `s_req` and `p_write_ready` never reach BRAM. A `p_write_ready` in SOLVE or DUMP sets `overrun`.
- `err_code` holds until the next IDLE→LOAD transition clears it. `overrun` clears only on reset.
- Address arithmetic: `RESULT_BASE+i` truncates to ADDR_W.

## Timing

- Reset values: all outputs 0; state IDLE; counters 0.
- Parser path: combinational pass-through to BRAM, zero added latency.
- Solver read latency: 1 cycle. Solver write: takes effect at the same edge.
- `s_start`: exactly 1 cycle, in the cycle after the LOAD→SOLVE edge.
- DUMP throughput: one cell per 2 cycles with `out_ready` held high (read, then present). Backpressure stalls without data loss. `out_data` is stable while `out_valid && !out_ready`.
- Reset mid-job: the sequencer returns to IDLE immediately and `s_start` is never re-issued. The parser and solver receive the same reset from the system.

## Structure

- `nonogram_pkg` holds:
  - state enum `seq_state_t` (IDLE, LOAD, SOLVE, DUMP);
  - error code localparams `ERR_NONE`, `ERR_UNSAT`, `ERR_TIMEOUT`, `ERR_DIMS`;
  - dimension width 12 and the default `ADDR_W`/`DATA_W`.
- One sub-module: `result_streamer`, which owns the DUMP address counter, read-latency tracking and the valid/ready output register. It is started by a pulse carrying `cells`, and returns a done pulse.

## Test plan

- 2x2 board, 4 parser writes then `p_board_done` (n=2, m=2) → 4 BRAM writes with matching addr/data, `s_start` pulse, `s_n`=`s_m`=2.
- Solver writes 1,0,0,1 at 0x8000–0x8003 then `s_done`, `out_ready`=1 → stream 1,0,0,1, `out_last` on the 4th cell, `busy` falls, `err_code`=0.
- Same job with `out_ready` toggling every 3 cycles → identical stream, no duplicated or dropped cells.
- `TIMEOUT_CYCLES`=100, solver silent → `err_code`=2 at SOLVE cycle 100, state IDLE; `s_done` and timeout in the same cycle → DUMP instead.
- `p_board_done` with n=0 → `err_code`=3, no `s_start`; a `p_write_ready` during SOLVE → `overrun`=1 and no BRAM write.
- `rst_n` asserted mid-DUMP → all outputs 0 asynchronously, IDLE; the next parser write starts LOAD normally.
